// File: rtl/pc_seq_pkg.sv
// Shared select encodings and error codes for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned ERR_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [ERR_W-1:0] err_t;

  localparam sel_t SEL_SEQ    = 3'b000;
  localparam sel_t SEL_JUMP   = 3'b001;
  localparam sel_t SEL_BRANCH = 3'b010;
  localparam sel_t SEL_CALL   = 3'b011;
  localparam sel_t SEL_RET    = 3'b100;

  localparam err_t ERR_NONE      = 2'b00;
  localparam err_t ERR_ILLEGAL   = 2'b01;
  localparam err_t ERR_UNDERFLOW = 2'b10;
  localparam err_t ERR_OVERFLOW  = 2'b11;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack on a circular buffer; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;

  // wr_ptr names the next free slot; the newest entry sits just below it
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = mem[top_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + PTR_W'(1);
      empty       <= 1'b0;
      if (!full) begin
        count <= count + CNT_W'(1);
        full  <= (count == CNT_W'(RAS_DEPTH - 1));
      end
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
      full   <= 1'b0;
      empty  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter: sequential, jump, relative branch, call and return with a RAS.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INC       = 4,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              stall,
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              err_valid,
  output logic [ERR_W-1:0]  err_code
);

  logic              accept;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] ras_top;
  err_t              err_d;
  logic              push;
  logic              pop;

  assign accept      = advance & ~stall;
  assign seq         = pc + ADDR_W'(INC);
  assign pc_next_seq = seq;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  // Next-PC select; RAS and error actions only when the instruction is accepted
  always_comb begin
    pc_d  = pc;
    err_d = ERR_NONE;
    push  = 1'b0;
    pop   = 1'b0;
    if (accept) begin
      case (sel)
        SEL_SEQ:    pc_d = seq;
        SEL_JUMP:   pc_d = target;
        SEL_BRANCH: pc_d = seq + target;
        SEL_CALL: begin
          push = 1'b1;
          pc_d = target;
          if (ras_full) err_d = ERR_OVERFLOW;
        end
        SEL_RET: begin
          if (ras_empty) begin
            pc_d  = seq;
            err_d = ERR_UNDERFLOW;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: begin
          pc_d  = seq;
          err_d = ERR_ILLEGAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= ADDR_W'(RESET_PC);
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      pc        <= pc_d;
      err_valid <= (err_d != ERR_NONE);
      err_code  <= err_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed check of pc_sequencer against a queue-based behavioural model.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        advance;
  logic        stall;
  logic [2:0]  sel;
  logic [15:0] target;
  logic [15:0] pc;
  logic [15:0] pc_next_seq;
  logic        ras_empty;
  logic        ras_full;
  logic        err_valid;
  logic [1:0]  err_code;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (advance),
    .stall       (stall),
    .sel         (sel),
    .target      (target),
    .pc          (pc),
    .pc_next_seq (pc_next_seq),
    .ras_empty   (ras_empty),
    .ras_full    (ras_full),
    .err_valid   (err_valid),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;

  // Behavioural model: PC value, RAS as a queue (newest at the back), last error
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ras [$];
  logic [1:0]  m_err = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ras.delete();
    m_err = 2'b00;
  endtask

  task automatic model_edge(input logic acc, input logic [2:0] s, input logic [15:0] t);
    logic [15:0] nseq;
    logic [15:0] ret;
    nseq  = m_pc + 16'd4;
    m_err = 2'b00;
    if (acc) begin
      case (s)
        3'd0: m_pc = nseq;
        3'd1: m_pc = t;
        3'd2: m_pc = nseq + t;
        3'd3: begin
          if (m_ras.size() == 4) begin
            void'(m_ras.pop_front());
            m_err = 2'b11;
          end
          m_ras.push_back(nseq);
          m_pc = t;
        end
        3'd4: begin
          if (m_ras.size() == 0) begin
            m_pc  = nseq;
            m_err = 2'b10;
          end else begin
            ret  = m_ras.pop_back();
            m_pc = ret;
          end
        end
        default: begin
          m_pc  = nseq;
          m_err = 2'b01;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_seq;
    exp_seq = m_pc + 16'd4;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_next_seq", 32'(pc_next_seq), 32'(exp_seq));
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
    chk("err_valid", 32'(err_valid), 32'(m_err != 2'b00));
    chk("err_code", 32'(err_code), 32'(m_err));
  endtask

  // One cycle: drive at negedge, model at posedge, compare at the next negedge
  task automatic step(input logic a, input logic s, input logic [2:0] sl, input logic [15:0] t);
    advance = a;
    stall   = s;
    sel     = sl;
    target  = t;
    @(posedge clk);
    model_edge(a && !s, sl, t);
    @(negedge clk);
    compare_all();
  endtask

  logic [15:0] held_pc;
  logic [2:0]  rsel;
  int          r;

  initial begin
    rst_n   = 1'b0;
    advance = 1'b0;
    stall   = 1'b0;
    sel     = 3'd0;
    target  = 16'h0000;
    model_reset();
    @(negedge clk);
    chk("reset_pc", 32'(pc), 32'h0000);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    chk("reset_full", 32'(ras_full), 32'd0);
    chk("reset_err", 32'(err_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // Sequential increments
    step(1, 0, 3'd0, 16'h0000); chk("seq1", 32'(pc), 32'h0004);
    step(1, 0, 3'd0, 16'h0000); chk("seq2", 32'(pc), 32'h0008);
    step(1, 0, 3'd0, 16'h0000); chk("seq3", 32'(pc), 32'h000C);
    chk("seq_empty", 32'(ras_empty), 32'd1);

    // Negative branch and wrap
    step(1, 0, 3'd1, 16'h0010); chk("jump", 32'(pc), 32'h0010);
    step(1, 0, 3'd2, 16'hFFF8); chk("branch_neg", 32'(pc), 32'h000C);
    step(1, 0, 3'd1, 16'hFFFC);
    step(1, 0, 3'd0, 16'h0000); chk("seq_wrap", 32'(pc), 32'h0000);

    // Call then immediate return
    step(1, 0, 3'd1, 16'h0020);
    step(1, 0, 3'd3, 16'h0100); chk("call_pc", 32'(pc), 32'h0100);
    chk("call_empty", 32'(ras_empty), 32'd0);
    step(1, 0, 3'd4, 16'h0000); chk("ret_pc", 32'(pc), 32'h0024);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Overflow on the fifth call, LIFO returns, then underflow
    step(1, 0, 3'd1, 16'h1000);
    for (int i = 0; i < 5; i++) step(1, 0, 3'd3, 16'h2000 + 16'(i * 16'h0100));
    chk("ovf_valid", 32'(err_valid), 32'd1);
    chk("ovf_code", 32'(err_code), 32'd3);
    chk("ovf_full", 32'(ras_full), 32'd1);
    step(1, 0, 3'd4, 16'h0000); chk("lifo1", 32'(pc), 32'h2304);
    chk("lifo1_err", 32'(err_valid), 32'd0);
    step(1, 0, 3'd4, 16'h0000); chk("lifo2", 32'(pc), 32'h2204);
    step(1, 0, 3'd4, 16'h0000); chk("lifo3", 32'(pc), 32'h2104);
    step(1, 0, 3'd4, 16'h0000); chk("lifo4", 32'(pc), 32'h2004);
    step(1, 0, 3'd4, 16'h0000); chk("unf_pc", 32'(pc), 32'h2008);
    chk("unf_code", 32'(err_code), 32'd2);

    // Stall overrides advance; illegal select
    held_pc = pc;
    for (int i = 0; i < 3; i++) step(1, 1, 3'd1, 16'hBEEF);
    chk("stall_pc", 32'(pc), 32'(held_pc));
    chk("stall_err", 32'(err_valid), 32'd0);
    step(1, 0, 3'd5, 16'h0000); chk("illegal_pc", 32'(pc), 32'(held_pc + 16'd4));
    chk("illegal_code", 32'(err_code), 32'd1);
    step(0, 0, 3'd0, 16'h0000); chk("err_clear", 32'(err_valid), 32'd0);

    // Random traffic with call/return weighting
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 15);
      if (r < 3)       rsel = 3'd0;
      else if (r < 5)  rsel = 3'd1;
      else if (r < 7)  rsel = 3'd2;
      else if (r < 11) rsel = 3'd3;
      else if (r < 15) rsel = 3'd4;
      else             rsel = 3'($urandom_range(5, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, rsel, 16'($urandom));
    end

    // Asynchronous reset in the middle of a call sequence
    step(1, 0, 3'd1, 16'h3000);
    step(1, 0, 3'd3, 16'h4000);
    step(1, 0, 3'd3, 16'h5000);
    advance = 1'b1;
    sel     = 3'd3;
    target  = 16'h6000;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_pc", 32'(pc), 32'h0000);
    chk("arst_empty", 32'(ras_empty), 32'd1);
    chk("arst_err", 32'(err_valid), 32'd0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(1, 0, 3'd0, 16'h0000); chk("post_rst_seq", 32'(pc), 32'h0004);
    step(1, 0, 3'd4, 16'h0000); chk("post_rst_unf", 32'(err_code), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
